// File: rtl/uart7n_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart7n_pkg
//  Description : Shared types and helpers for the uart7n arbiter slice:
//                sequencer state encoding, byte width and a ceil-log2
//                helper used to size pointers and timers.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart7n_pkg;

    // Width of one UART payload byte.
    localparam int UART7N_BYTE_W = 8;

    // Sequencer states: waiting for a producer, pulsing enable until the
    // transmitter reports busy, and holding the byte until the frame is sent.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Ceil(log2(n)), minimum 1 so a 2-entry pointer still has one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int k = 1; k < 32; k++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage : uart7n_pkg
`default_nettype wire

// File: rtl/uart7n_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : uart7n_rr_picker
//  Description : Combinational round-robin picker. Returns the requester
//                closest after last_i in circular order, as one-hot and as
//                an index, plus an any-request flag. Written generically so
//                an RX distributor can reuse it.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart7n_rr_picker
    import uart7n_pkg::*;
#(
    parameter int P_NUM_REQ = 4,
    parameter int P_IDX_W   = clog2(P_NUM_REQ)
) (
    input  logic [P_NUM_REQ-1:0] req_i,
    input  logic [P_IDX_W-1:0]   last_i,
    output logic [P_NUM_REQ-1:0] onehot_o,
    output logic [P_IDX_W-1:0]   idx_o,
    output logic                 any_o
);

    int w_dist;
    int w_best_d;

    // Pick the requesting index with the smallest circular distance past last_i.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        w_dist   = 0;
        w_best_d = P_NUM_REQ;
        for (int i = 0; i < P_NUM_REQ; i++) begin
            // Distance 0 means "immediately after last", P_NUM_REQ-1 means "last itself".
            w_dist = (i - int'(last_i) - 1 + 2 * P_NUM_REQ) % P_NUM_REQ;
            if (req_i[i] && (w_dist < w_best_d)) begin
                w_best_d    = w_dist;
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
                idx_o       = P_IDX_W'(i);
                any_o       = 1'b1;
            end
        end
    end

endmodule : uart7n_rr_picker
`default_nettype wire

// File: rtl/uart7n_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart7n_tx_arbiter
//  Description : Round-robin arbiter/sequencer sharing one UART transmitter
//                among P_NUM_REQ byte producers. Accepts a byte over a
//                valid/ready handshake, pulses the transmitter enable until
//                it reports busy, then holds the byte until the frame is sent.
//                A start that never sees busy is abandoned with start_err_o.
//  Options     : UART7N_ARB_LOCK_EN - adds lock_i so the previous winner can
//                keep ownership across frames (unbroken multi-byte packets).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart7n_tx_arbiter
    import uart7n_pkg::*;
#(
    parameter int P_NUM_REQ       = 4,
    parameter int P_START_TIMEOUT = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [P_NUM_REQ-1:0]                 req_valid_i,
    input  logic [UART7N_BYTE_W*P_NUM_REQ-1:0]   req_data_i,
`ifdef UART7N_ARB_LOCK_EN
    input  logic [P_NUM_REQ-1:0]                 lock_i,
`endif
    output logic [P_NUM_REQ-1:0]                 req_ready_o,
    output logic [UART7N_BYTE_W-1:0]             tx_data_o,
    output logic                                 tx_enable_o,
    input  logic                                 tx_busy_i,
    input  logic                                 tx_data_sent_i,
    output logic [P_NUM_REQ-1:0]                 grant_o,
    output logic                                 busy_o,
    output logic                                 start_err_o
);

    localparam int                IDX_W    = clog2(P_NUM_REQ);
    localparam int                TMR_W    = clog2(P_START_TIMEOUT);
    // Pointer resets to the top index so requester 0 is scanned first.
    localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(P_NUM_REQ - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(P_START_TIMEOUT - 1);

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            last_q, last_d;
    logic [TMR_W-1:0]            timer_q, timer_d;
    logic [UART7N_BYTE_W-1:0]    data_q, data_d;
    logic [P_NUM_REQ-1:0]        grant_q, grant_d;

    logic [P_NUM_REQ-1:0]        w_elig;
    logic [P_NUM_REQ-1:0]        w_pick_oh;
    logic [IDX_W-1:0]            w_pick_idx;
    logic                        w_pick_any;
    logic [UART7N_BYTE_W-1:0]    w_win_data;

`ifdef UART7N_ARB_LOCK_EN
    // Set for exactly the IDLE cycle that follows a start timeout, so a
    // stuck owner cannot keep the lock across a failed frame.
    logic                        lock_clr_q, lock_clr_d;
    logic                        w_lock_hit;
    logic [P_NUM_REQ-1:0]        w_last_oh;

    // Restrict eligibility to the previous winner while it holds its lock.
    always_comb begin
        w_lock_hit = 1'b0;
        w_last_oh  = '0;
        for (int i = 0; i < P_NUM_REQ; i++) begin
            if (i == int'(last_q)) begin
                w_last_oh[i] = 1'b1;
                w_lock_hit   = lock_i[i];
            end
        end
        if (w_lock_hit && !lock_clr_q) begin
            w_elig = req_valid_i & w_last_oh;
        end else begin
            w_elig = req_valid_i;
        end
    end

    // Remember a timeout for the single following cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_clr_q <= 1'b0;
        end else begin
            lock_clr_q <= lock_clr_d;
        end
    end

    assign lock_clr_d = start_err_o;
`else
    assign w_elig = req_valid_i;
`endif

    uart7n_rr_picker #(
        .P_NUM_REQ (P_NUM_REQ),
        .P_IDX_W   (IDX_W)
    ) u_picker (
        .req_i    (w_elig),
        .last_i   (last_q),
        .onehot_o (w_pick_oh),
        .idx_o    (w_pick_idx),
        .any_o    (w_pick_any)
    );

    // Select the winner's byte from the packed data bus.
    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < P_NUM_REQ; i++) begin
            if (w_pick_oh[i]) begin
                w_win_data = req_data_i[i*UART7N_BYTE_W +: UART7N_BYTE_W];
            end
        end
    end

    // State, pointer, timer and latched-frame registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= LAST_RST;
            timer_q <= '0;
            data_q  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            grant_q <= grant_d;
        end
    end

    // Next-state logic plus the handshake/enable/error outputs.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        timer_d     = timer_q;
        data_d      = data_q;
        grant_d     = grant_q;
        req_ready_o = '0;
        tx_enable_o = 1'b0;
        start_err_o = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                // Ready is withheld during reset so no byte is consumed and lost.
                if (w_pick_any && !rst_i) begin
                    req_ready_o = w_pick_oh;
                    data_d      = w_win_data;
                    grant_d     = w_pick_oh;
                    last_d      = w_pick_idx;
                    state_d     = START;
                end
            end

            START: begin
                tx_enable_o = 1'b1;
                // Busy has priority over the timeout in the final cycle.
                if (tx_busy_i) begin
                    state_d = WAIT;
                    timer_d = '0;
                end else if (timer_q == TMR_LAST) begin
                    start_err_o = 1'b1;
                    grant_d     = '0;
                    timer_d     = '0;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            WAIT: begin
                if (!tx_busy_i && tx_data_sent_i) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign tx_data_o = data_q;
    assign grant_o   = grant_q;
    assign busy_o    = (state_q != IDLE);

endmodule : uart7n_tx_arbiter
`default_nettype wire

// File: tb/tb_uart7n_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart7n_tx_arbiter
//  Description : Self-checking bench for uart7n_tx_arbiter with a queue-based
//                producer model, a behavioural UART TX model and a
//                round-robin reference model.
//  Options     : UART7N_ARB_LOCK_EN - also exercises lock_i.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart7n_tx_arbiter;

    localparam int N = 4;
    localparam int T = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [8*N-1:0]   req_data = '0;
    logic [N-1:0]     req_ready;
    logic [7:0]       tx_data;
    logic             tx_en;
    logic             tx_busy = 1'b0;
    logic             tx_sent = 1'b0;
    logic [N-1:0]     grant;
    logic             busy_o;
    logic             err;
`ifdef UART7N_ARB_LOCK_EN
    logic [N-1:0]     lock = '0;
`endif

    always #5 clk = ~clk;

    uart7n_tx_arbiter #(
        .P_NUM_REQ       (N),
        .P_START_TIMEOUT (T)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
`ifdef UART7N_ARB_LOCK_EN
        .lock_i         (lock),
`endif
        .req_ready_o    (req_ready),
        .tx_data_o      (tx_data),
        .tx_enable_o    (tx_en),
        .tx_busy_i      (tx_busy),
        .tx_data_sent_i (tx_sent),
        .grant_o        (grant),
        .busy_o         (busy_o),
        .start_err_o    (err)
    );

    int total = 0;
    int bad   = 0;

    // Producer model: one FIFO of bytes per requester.
    logic [7:0] pmem [N][256];
    int         phead [N];
    int         ptail [N];
    bit         acc_flag [N];

    typedef struct {
        int           idx;
        logic [N-1:0] vld;
        logic [7:0]   data;
        int           cyc;
        logic [N-1:0] gnt;
    } acc_t;

    acc_t acc_log [$];
    int   done_cyc [$];
    int   cyc = 0;
    int   ready_bad, en_cycles, err_cnt, err_cyc, err_at, start_cnt;
    int   ready_cnt [N];
    int   uart_mode = 0;
    int   busy_dly  = 2;
    int   frame_len = 8;
    int   en_run, frame_cnt;

    // Present the head of each queue; pop after an observed accept.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_flag[i]) begin
                phead[i]    = phead[i] + 1;
                acc_flag[i] = 1'b0;
            end
            req_valid[i]        = (phead[i] != ptail[i]);
            req_data[i*8 +: 8]  = (phead[i] != ptail[i]) ? pmem[i][phead[i]] : 8'h00;
        end
    end

    // Monitor (samples first) followed by the UART TX model (drives after).
    always @(negedge clk) begin
        acc_t e;
        cyc = cyc + 1;
        if (rst) begin
            tx_busy = 1'b0; tx_sent = 1'b0; en_run = 0; frame_cnt = 0; start_cnt = 0;
        end else begin
            if (req_ready != '0) begin
                if (busy_o || $countones(req_ready) != 1 || (req_ready & ~req_valid) != '0)
                    ready_bad = ready_bad + 1;
                for (int i = 0; i < N; i++) begin
                    if (req_ready[i] && req_valid[i]) begin
                        e.idx = i; e.vld = req_valid; e.data = req_data[i*8 +: 8];
                        e.cyc = cyc; e.gnt = grant;
                        acc_log.push_back(e);
                        acc_flag[i]  = 1'b1;
                        ready_cnt[i] = ready_cnt[i] + 1;
                    end
                end
                start_cnt = 0;
            end
            if (tx_en) begin
                en_cycles = en_cycles + 1;
                start_cnt = start_cnt + 1;
            end
            if (err) begin
                err_cnt = err_cnt + 1; err_cyc = cyc; err_at = start_cnt;
            end
            tx_sent = 1'b0;
            if (!tx_busy) begin
                if (tx_en && uart_mode == 0) begin
                    en_run = en_run + 1;
                    if (en_run >= busy_dly) begin
                        tx_busy = 1'b1; en_run = 0; frame_cnt = 0;
                    end
                end else begin
                    en_run = 0;
                end
            end else begin
                frame_cnt = frame_cnt + 1;
                if (frame_cnt >= frame_len) begin
                    tx_busy = 1'b0; tx_sent = 1'b1; done_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int r, input logic [7:0] b);
        pmem[r][ptail[r]] = b;
        ptail[r] = ptail[r] + 1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            phead[i] = 0; ptail[i] = 0; acc_flag[i] = 1'b0; ready_cnt[i] = 0;
        end
        acc_log.delete(); done_cyc.delete();
        ready_bad = 0; en_cycles = 0; err_cnt = 0; err_cyc = 0; err_at = 0;
        uart_mode = 0;
`ifdef UART7N_ARB_LOCK_EN
        lock = '0;
`endif
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max; c++) begin
            bit empty;
            step();
            empty = 1'b1;
            for (int i = 0; i < N; i++)
                if (phead[i] != ptail[i] || acc_flag[i]) empty = 1'b0;
            if (empty && !busy_o) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_accepts(input int n, input int max, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max; c++) begin
            step();
            if (acc_log.size() >= n) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
        total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL reset_tx_enable got=%b want=0", tx_en); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_start_err got=%b want=0", err); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    endtask

    task automatic test_single();
        int  hold_bad;
        bit  ok;
        do_reset();
        busy_dly = 2; frame_len = 20; hold_bad = 0; ok = 1'b0;
        push(0, 8'h41);
        for (int c = 0; c < 100; c++) begin
            step();
            if (busy_o && (tx_data !== 8'h41 || grant !== 4'b0001)) hold_bad++;
            if (acc_log.size() == 1 && done_cyc.size() == 1 && !busy_o) begin
                ok = 1'b1;
                break;
            end
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL single_timeout got=%b want=1", ok); end
        total++; if (ready_cnt[0] !== 1) begin bad++; $display("FAIL single_ready_pulses got=%0d want=1", ready_cnt[0]); end
        total++; if (acc_log.size() > 0 && acc_log[0].data !== 8'h41) begin bad++; $display("FAIL single_data got=%h want=41", acc_log[0].data); end
        total++; if (en_cycles !== 2) begin bad++; $display("FAIL single_enable_cycles got=%0d want=2", en_cycles); end
        total++; if (hold_bad !== 0) begin bad++; $display("FAIL single_hold got=%0d want=0", hold_bad); end
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL single_grant_end got=%b want=0000", grant); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b want=0", busy_o); end
        total++; if (err_cnt !== 0) begin bad++; $display("FAIL single_err got=%0d want=0", err_cnt); end
    endtask

    task automatic test_rotate();
        int         exp_idx [5];
        logic [7:0] exp_dat [5];
        bit         ok;
        exp_idx = '{0, 1, 2, 3, 0};
        exp_dat = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        do_reset();
        busy_dly = 1; frame_len = 5;
        push(0, 8'h10); push(0, 8'h10); push(1, 8'h11); push(2, 8'h12); push(3, 8'h13);
        wait_idle(400, ok);
        total++; if (ok !== 1'b1 || acc_log.size() != 5) begin bad++; $display("FAIL rotate_count got=%0d want=5", acc_log.size()); end
        for (int k = 0; k < 5 && k < acc_log.size(); k++) begin
            total++;
            if (acc_log[k].idx !== exp_idx[k] || acc_log[k].data !== exp_dat[k]) begin
                bad++; $display("FAIL rotate_order[%0d] got=%0d/%h want=%0d/%h", k, acc_log[k].idx, acc_log[k].data, exp_idx[k], exp_dat[k]);
            end
        end
        total++; if (ready_cnt[0] !== 2 || ready_cnt[1] !== 1 || ready_cnt[2] !== 1 || ready_cnt[3] !== 1) begin
            bad++; $display("FAIL rotate_ready_pulses got=%0d,%0d,%0d,%0d want=2,1,1,1", ready_cnt[0], ready_cnt[1], ready_cnt[2], ready_cnt[3]);
        end
        total++; if (ready_bad !== 0) begin bad++; $display("FAIL rotate_ready_protocol got=%0d want=0", ready_bad); end
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        uart_mode = 1; busy_dly = 2; frame_len = 5;
        push(0, 8'hA5); push(2, 8'hC3);
        wait_accepts(2, 80, ok);
        uart_mode = 0;
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL timeout_second_accept got=%b want=1", ok); end
        wait_idle(200, ok);
        total++; if (err_cnt !== 1) begin bad++; $display("FAIL timeout_err_pulses got=%0d want=1", err_cnt); end
        total++; if (err_at !== T) begin bad++; $display("FAIL timeout_err_cycle got=%0d want=%0d", err_at, T); end
        if (acc_log.size() >= 2) begin
            total++; if (acc_log[0].idx !== 0 || acc_log[1].idx !== 2) begin bad++; $display("FAIL timeout_order got=%0d,%0d want=0,2", acc_log[0].idx, acc_log[1].idx); end
            total++; if (acc_log[1].cyc - err_cyc !== 1) begin bad++; $display("FAIL timeout_reaccept_gap got=%0d want=1", acc_log[1].cyc - err_cyc); end
            total++; if (acc_log[1].gnt !== 4'b0000) begin bad++; $display("FAIL timeout_grant_cleared got=%b want=0000", acc_log[1].gnt); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int base;
        do_reset();
        busy_dly = 1; frame_len = 30;
        push(0, 8'h77);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (acc_log.size() == 1 && busy_o && !tx_en) begin
                ok = 1'b1;
                break;
            end
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL midreset_reach_wait got=%b want=1", ok); end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if ({grant, tx_data, tx_en, busy_o, err, req_ready} !== '0) begin
            bad++; $display("FAIL midreset_outputs got=g%b d%h e%b b%b s%b r%b want=all0", grant, tx_data, tx_en, busy_o, err, req_ready);
        end
        base = acc_log.size();
        push(1, 8'h78); push(0, 8'h70);
        wait_idle(300, ok);
        total++; if (acc_log.size() != base + 2 || acc_log[base].idx !== 0) begin
            bad++; $display("FAIL midreset_first_grant got=%0d want=0", (acc_log.size() > base) ? acc_log[base].idx : -1);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        busy_dly = 1; frame_len = 6;
        for (int k = 0; k < 4; k++) push(2, 8'h55);
        wait_idle(300, ok);
        total++; if (ok !== 1'b1 || acc_log.size() != 4 || done_cyc.size() != 4) begin
            bad++; $display("FAIL b2b_count got=%0d/%0d want=4/4", acc_log.size(), done_cyc.size());
        end
        for (int k = 1; k < 4 && k < acc_log.size() && k <= done_cyc.size(); k++) begin
            total++;
            if (acc_log[k].cyc - done_cyc[k-1] !== 1 || acc_log[k].idx !== 2 || acc_log[k].data !== 8'h55) begin
                bad++; $display("FAIL b2b_gap[%0d] got=%0d idx=%0d data=%h want=1 idx=2 data=55", k, acc_log[k].cyc - done_cyc[k-1], acc_log[k].idx, acc_log[k].data);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int mlast, best, used [N], pushed;
        do_reset();
        pushed = 0;
        for (int c = 0; c < 300; c++) begin
            step();
            if (c % 40 == 0) begin
                busy_dly  = $urandom_range(1, 4);
                frame_len = $urandom_range(2, 12);
            end
            if ($urandom_range(0, 5) == 0) begin
                push($urandom_range(0, N-1), 8'($urandom));
                pushed++;
            end
        end
        wait_idle(3000, ok);
        total++; if (ok !== 1'b1 || acc_log.size() != pushed) begin bad++; $display("FAIL random_count got=%0d want=%0d", acc_log.size(), pushed); end
        mlast = N - 1;
        for (int i = 0; i < N; i++) used[i] = 0;
        for (int e = 0; e < acc_log.size(); e++) begin
            best = -1;
            for (int k = 1; k <= N && best < 0; k++)
                if (acc_log[e].vld[(mlast + k) % N]) best = (mlast + k) % N;
            total++;
            if (best < 0 || acc_log[e].idx !== best || acc_log[e].data !== pmem[best][used[best]]) begin
                bad++; $display("FAIL random_accept[%0d] got=%0d/%h want=%0d/%h", e, acc_log[e].idx, acc_log[e].data, best, (best >= 0) ? pmem[best][used[best]] : 8'h00);
            end
            if (best >= 0) begin
                used[best]++;
                mlast = best;
            end
        end
        total++; if (ready_bad !== 0 || err_cnt !== 0) begin bad++; $display("FAIL random_protocol got=%0d/%0d want=0/0", ready_bad, err_cnt); end
    endtask

`ifdef UART7N_ARB_LOCK_EN
    task automatic test_lock();
        bit ok;
        int n1;
        int exp_idx [5];
        exp_idx = '{1, 1, 1, 3, 1};
        do_reset();
        busy_dly = 2; frame_len = 4;
        lock = 4'b0010;
        push(1, 8'h61); push(1, 8'h62); push(1, 8'h63); push(1, 8'h64); push(3, 8'h33);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            step();
            n1 = 0;
            for (int k = 0; k < acc_log.size(); k++) if (acc_log[k].idx == 1) n1++;
            if (n1 >= 3) lock = 4'b0000;
            if (acc_log.size() == 5 && !busy_o) begin
                ok = 1'b1;
                break;
            end
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL lock_count got=%0d want=5", acc_log.size()); end
        for (int k = 0; k < 5 && k < acc_log.size(); k++) begin
            total++;
            if (acc_log[k].idx !== exp_idx[k]) begin bad++; $display("FAIL lock_order[%0d] got=%0d want=%0d", k, acc_log[k].idx, exp_idx[k]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_rotate();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef UART7N_ARB_LOCK_EN
        test_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_uart7n_tx_arbiter
`default_nettype wire

// File: doc/uart7n_tx_arbiter.md
Name: uart7n_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares a single UART transmitter (uart7n_top TX side) among P_NUM_REQ byte producers.
- Accepts bytes over per-requester valid/ready handshakes, latches the winner's byte, and drives the transmitter's data and enable inputs.
- Holds the byte stable until the transmitter reports completion.
- Sits between on-chip producers (debug console, status reporter, loopback echo) and uart7n_top.

Parameters:
- P_NUM_REQ, 4, number of requesters (2..16).
- P_START_TIMEOUT, 16, cycles to wait for tx_busy_i after enabling before the frame is declared failed (>=2).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- req_valid_i  in  P_NUM_REQ  per-requester byte valid
- req_data_i  in  8*P_NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i]
- req_ready_o  out  P_NUM_REQ  per-requester accept; transfer occurs when valid and ready are both high
- tx_data_o  out  8  to UART data_tx_i
- tx_enable_o  out  1  to UART enable_tx_i
- tx_busy_i  in  1  from UART tx_busy_o
- tx_data_sent_i  in  1  from UART tx_data_sent_o
- grant_o  out  P_NUM_REQ  one-hot owner of the current frame; all zero when idle
- busy_o  out  1  arbiter not in IDLE
- start_err_o  out  1  one-cycle pulse on start timeout

Behaviour:
- Reset values:
  - state IDLE; all outputs 0.
  - last-grant pointer = P_NUM_REQ-1, so requester 0 has first priority after reset.
  - Timer 0.
- Reset mid-frame: returns to IDLE immediately and drops the latched byte. The UART is reset independently.
- IDLE:
  - Winner = first requester with req_valid_i high, scanning circularly from (last+1) mod P_NUM_REQ.
  - req_ready_o[winner] is driven combinationally high in the same cycle; all other ready bits are 0.
  - On that clock edge:
    - tx_data_o <= winner data;
    - grant_o <= onehot(winner);
    - last <= winner;
    - go to START.
  - With no valid requester, stay in IDLE.
- START:
  - tx_enable_o = 1; timer increments each cycle.
  - tx_busy_i = 1: go to WAIT and clear the timer.
  - Timer reaches P_START_TIMEOUT-1 with tx_busy_i still 0:
    - pulse start_err_o;
    - clear grant_o;
    - go to IDLE (byte dropped).
- WAIT:
  - tx_enable_o = 0; tx_data_o and grant_o are held.
  - When tx_busy_i = 0 and tx_data_sent_i = 1: go to IDLE and clear grant_o.
- Latency:
  - Accept to tx_enable_o high: 1 cycle.
  - End of frame to next accept: 1 cycle minimum (the IDLE cycle).
- Requester rules:
  - req_valid_i must stay high with stable data until accepted.
  - The arbiter never asserts ready outside IDLE.
  - A valid dropped before acceptance is legal and simply loses arbitration.
- Simultaneous events:
  - If tx_busy_i rises in the timeout cycle, busy wins and there is no error.
  - All requesters valid: grant order is strictly rotating, 0,1,2,3,0,...
- Fairness: no requester waits more than P_NUM_REQ-1 frames.

Optional Feature:
- Macro: UART7N_ARB_LOCK_EN.
- Enabled:
  - Adds input lock_i [P_NUM_REQ].
  - If lock_i[last] is high in IDLE, only requester "last" is eligible; others see ready 0 even when valid. Multi-byte packets are therefore sent unbroken.
  - Arbitration resumes round-robin on the first IDLE cycle with lock_i[last] low.
  - A timeout error also clears the lock effect for that IDLE cycle.
- Disabled: no lock_i port; pure round-robin.

Decomposition:
- Shared package uart7n_pkg:
  - state enum {IDLE, START, WAIT} (2 bits);
  - function clog2 for pointer width;
  - constant UART7N_BYTE_W = 8.
- One sub-module, uart7n_rr_picker (combinational):
  - inputs: request vector, last pointer;
  - outputs: one-hot winner, index, any-valid.
  - Reusable for a future RX distributor.

Test Plan:
- Reset, then req_valid_i=4'b0001 with byte 0x41; model UART raises busy 2 cycles after enable and drops busy + raises sent after 20 cycles -> ready[0] pulses once, tx_data_o=0x41 held, tx_enable_o high exactly 2 cycles, grant_o=0001 until completion, busy_o returns 0.
- All four valid with bytes 0x10,0x11,0x12,0x13 held -> transmit order 0x10,0x11,0x12,0x13, then 0x10 again; each requester's ready pulses exactly once per frame.
- UART never raises busy -> start_err_o pulses once in cycle 16 of START, grant_o clears, next valid requester is accepted 1 cycle later.
- rst_i asserted for 1 cycle during WAIT -> next cycle all outputs 0; the next accept goes to requester 0 regardless of prior pointer.
- Only requester 2 valid, continuously with 0x55 -> back-to-back frames with exactly 1 IDLE cycle between completion and the next ready[2].
- UART7N_ARB_LOCK_EN defined, lock_i[1]=1 for 3 bytes while requester 3 is valid -> requester 1 sends 3 consecutive frames; requester 3 is granted on the frame after lock drops.
